// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter for up to 32 requesters.
// A rotating pointer sets the starting priority. A grant is held until the
// owner raises done_i or the hold counter reaches MAX_HOLD cycles.

module rr_arbiter #(
   parameter int N        = 32,
   parameter int IDW      = 5,
   parameter int MAX_HOLD = 255
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic [N-1:0]   req_i,
   input  logic           done_i,
   output logic [N-1:0]   gnt_o,
   output logic [IDW-1:0] gnt_id_o,
   output logic           gnt_valid_o,
   output logic           timeout_o
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   logic [0:0]     state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [15:0]    cnt_q, cnt_d;
   logic [N-1:0]   gnt_q, gnt_d;
   logic [IDW-1:0] id_q, id_d;
   logic           tmo_q, tmo_d;

   logic [IDW-1:0] winIdx;
   logic           winValid;
   logic [IDW-1:0] ptrNext;
   logic           holdExpired;

   // Find the first active request scanning upward from the pointer, wrapping at N-1.
   always_comb begin
      int             pos;
      logic [IDW-1:0] posIdx;
      winIdx   = '0;
      winValid = 1'b0;
      pos      = 0;
      posIdx   = '0;
      for (int i = 0; i < N; i++) begin
         pos = int'(ptr_q) + i;
         if (pos >= N) begin
            pos = pos - N;
         end
         posIdx = IDW'(pos);
         if (!winValid && req_i[posIdx]) begin
            winValid = 1'b1;
            winIdx   = posIdx;
         end
      end
   end

   assign ptrNext     = (id_q == IDW'(N - 1)) ? '0 : id_q + IDW'(1);
   assign holdExpired = (cnt_q == 16'(MAX_HOLD - 1));

   // Next-state logic: arbitrate in IDLE, hold and count in GRANT until release.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      id_d    = id_q;
      tmo_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (winValid) begin
               state_d       = GRANT;
               gnt_d         = '0;
               gnt_d[winIdx] = 1'b1;
               id_d          = winIdx;
               cnt_d         = '0;
            end
         end
         GRANT: begin
            if (done_i || holdExpired) begin
               state_d = IDLE;
               gnt_d   = '0;
               id_d    = '0;
               cnt_d   = '0;
               ptr_d   = ptrNext;
               tmo_d   = !done_i;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers with synchronous reset that abandons any held grant silently.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         id_q    <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         id_q    <= id_d;
         tmo_q   <= tmo_d;
      end
   end

   assign gnt_o       = gnt_q;
   assign gnt_id_o    = id_q;
   assign gnt_valid_o = |gnt_q;
   assign timeout_o   = tmo_q;

endmodule
